control_puertas_param: RTL and testbench
========================================

Name: control_puertas_param

Overview:
Parametrised, clocked successor of the elevator door controller, generalised to N_PISOS floors. Per-floor calls plus the current floor and motion status select when to open. An internal FSM drives the door motor from the limit switches and runs its own open-hold timer, obstruction re-open counter and motor watchdog. It sits between the floor-request logic and the door motor driver. `trabajando` holds the car controller off while the doors are in service.

Parameters:
N_PISOS, 4, number of floors (≥2); floor index width PW = $clog2(N_PISOS)
T_ABIERTA, 50, cycles doors stay fully open before auto-close
T_MOTOR_MAX, 20, max cycles allowed for an open or close stroke before fault
MAX_REAPERTURAS, 3, re-opens allowed per service before nudge (NUDGE_EN only)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
solicitud  in  N_PISOS  pending call per floor (inside or outside, already direction-filtered)
piso_actual  in  PW  current floor index
moviendo  in  1  car in motion
boton_abrir  in  1  open-door button (level)
boton_cerrar  in  1  close-door button (level)
sensor  in  1  obstruction between doors
fin_apertura  in  1  limit switch: fully open
fin_cierre  in  1  limit switch: fully closed
motor_abrir  out  1  drive doors open
motor_cerrar  out  1  drive doors closed
estado_puertas  out  2  00 closed, 01 open, 10 closing, 11 opening
aviso  out  N_PISOS  one-hot chime, 1-cycle pulse
atendido  out  1  1-cycle pulse: call at piso_actual serviced, upstream clears it
trabajando  out  1  door block busy; car must not move
falla  out  1  sticky fault

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state CERRADA, all outputs 0, timers/counters 0. Reset mid-stroke drops both motors immediately.
- All outputs registered. motor_abrir and motor_cerrar are never 1 together.
- States and encodings (estado_puertas): CERRADA 00, ABIERTA 01, CERRANDO 10, ABRIENDO 11.
- CERRADA:
  - Go to ABRIENDO when !moviendo and (solicitud[piso_actual] or boton_abrir).
  - On that transition edge: aviso[piso_actual]=1 for 1 cycle; atendido=1 for 1 cycle only if solicitud[piso_actual].
  - trabajando=0 only in CERRADA with no transition pending.
- ABRIENDO:
  - motor_abrir=1; stroke counter counts up.
  - fin_apertura: go to ABIERTA, load hold timer with T_ABIERTA.
- ABIERTA:
  - Motors off; hold timer decrements to 0 and saturates.
  - sensor, boton_abrir or solicitud[piso_actual] reloads the timer to T_ABIERTA (atendido pulses for solicitud).
  - Go to CERRANDO when (boton_cerrar or timer==0) and !sensor and !boton_abrir. boton_abrir beats boton_cerrar when both are asserted.
- CERRANDO:
  - motor_cerrar=1.
  - sensor, boton_abrir or solicitud[piso_actual]: go to ABRIENDO, re-open counter +1 (saturating), stroke counter cleared.
  - fin_cierre with no re-open cause: go to CERRADA, re-open counter cleared.
  - When a re-open cause and fin_cierre coincide, the re-open wins.
- Watchdog:
  - Stroke counter resets on every state entry.
  - Reaching T_MOTOR_MAX in ABRIENDO or CERRANDO without the limit switch: falla=1, both motors 0, FSM frozen.
  - While frozen: estado_puertas holds, trabajando=1 until rst_n.
- Safety:
  - moviendo=1 in any state other than CERRADA sets falla (same freeze).
  - piso_actual ≥ N_PISOS is treated as no call; no aviso.
- Counter widths: $clog2(max+1). No wrap-around; all counters saturate.

Optional Feature:
NUDGE_EN.
- Defined: when the re-open counter reaches MAX_REAPERTURAS, the next CERRANDO ignores sensor (buttons and solicitud still re-open). aviso[piso_actual] is held high for the whole nudge close. The counter clears on CERRADA.
- Undefined: no nudge; sensor always re-opens; MAX_REAPERTURAS is unused.

Test Plan:
- Reset, then solicitud=0100, piso_actual=2, moviendo=0 → next edge: estado 11, motor_abrir=1, aviso=0100 and atendido for 1 cycle.
- fin_apertura → estado 01; no inputs → CERRANDO exactly T_ABIERTA cycles later (50); fin_cierre → estado 00, trabajando=0.
- sensor pulse in CERRANDO → estado 11 next cycle, re-open count 1. In ABIERTA, sensor at timer=10 reloads the timer to 50.
- boton_abrir and boton_cerrar both asserted in ABIERTA → stays 01, timer reloaded. boton_cerrar alone → 10 next cycle.
- Hold fin_apertura low in ABRIENDO for 20 cycles → falla=1, motors 0, trabajando=1 until rst_n. Separately, moviendo=1 in ABIERTA → falla=1.
- NUDGE_EN, 3 sensor re-opens, then sensor held in 4th close → stays 10 with aviso held, reaches 00 on fin_cierre. Without NUDGE_EN → re-opens.

Source files
------------

// File: rtl/control_puertas_param.sv
// Door controller for an N_PISOS-floor car: opens on a call or the open button, holds, closes,
// re-opens on obstruction, and latches a fault on a stuck stroke or a moving car. `NUDGE_EN` adds forced-close nudging.
module control_puertas_param #(
  parameter int N_PISOS         = 4,
  parameter int T_ABIERTA       = 50,
  parameter int T_MOTOR_MAX     = 20,
  parameter int MAX_REAPERTURAS = 3,
  localparam int PW = $clog2(N_PISOS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PISOS-1:0] solicitud,
  input  logic [PW-1:0]      piso_actual,
  input  logic               moviendo,
  input  logic               boton_abrir,
  input  logic               boton_cerrar,
  input  logic               sensor,
  input  logic               fin_apertura,
  input  logic               fin_cierre,
  output logic               motor_abrir,
  output logic               motor_cerrar,
  output logic [1:0]         estado_puertas,
  output logic [N_PISOS-1:0] aviso,
  output logic               atendido,
  output logic               trabajando,
  output logic               falla
);
  localparam int HW = $clog2(T_ABIERTA + 1);
  localparam int SW = $clog2(T_MOTOR_MAX + 1);
  localparam int RW = $clog2(MAX_REAPERTURAS + 1);

  typedef enum logic [1:0] {
    CERRADA  = 2'b00,
    ABIERTA  = 2'b01,
    CERRANDO = 2'b10,
    ABRIENDO = 2'b11
  } estado_t;

  estado_t           state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d, hold_dec;
  logic [SW-1:0]     stroke_q, stroke_d;
  logic [RW-1:0]     reab_q, reab_d, reab_inc;
  logic              falla_q, falla_d;
  logic              motor_abrir_q, motor_abrir_d;
  logic              motor_cerrar_q, motor_cerrar_d;
  logic              atendido_q, atendido_d;
  logic              trabajando_q, trabajando_d;
  logic [N_PISOS-1:0] aviso_q, aviso_d;
  logic [N_PISOS-1:0] sel;
  logic              call, nudge_now, stroke_exp;

  always_comb begin
    sel  = '0;
    call = 1'b0;
    // An out-of-range floor index matches no entry, so it is neither a call nor a chime.
    for (int i = 0; i < N_PISOS; i++) begin
      if (piso_actual == PW'(i)) begin
        sel[i] = 1'b1;
        call   = solicitud[i];
      end
    end
    hold_dec   = (hold_q == '0) ? '0 : hold_q - 1'b1;
    reab_inc   = (reab_q == RW'(MAX_REAPERTURAS)) ? reab_q : reab_q + 1'b1;
    stroke_exp = (stroke_q == SW'(T_MOTOR_MAX - 1));
`ifdef NUDGE_EN
    nudge_now  = (reab_q == RW'(MAX_REAPERTURAS));
`else
    nudge_now  = 1'b0;
`endif

    state_d    = state_q;
    hold_d     = hold_q;
    stroke_d   = stroke_q;
    reab_d     = reab_q;
    falla_d    = falla_q;
    aviso_d    = '0;
    atendido_d = 1'b0;

    if (!falla_q) begin
      if (moviendo && state_q != CERRADA) begin
        falla_d = 1'b1;
      end else begin
        case (state_q)
          CERRADA: begin
            if (!moviendo && (call || boton_abrir)) begin
              state_d    = ABRIENDO;
              aviso_d    = sel;
              atendido_d = call;
            end
          end
          ABRIENDO: begin
            if (fin_apertura) begin
              state_d = ABIERTA;
              hold_d  = HW'(T_ABIERTA);
            end else if (stroke_exp) begin
              falla_d = 1'b1;
            end else begin
              stroke_d = stroke_q + 1'b1;
            end
          end
          ABIERTA: begin
            atendido_d = call;
            hold_d     = (sensor || boton_abrir || call) ? HW'(T_ABIERTA) : hold_dec;
            // hold_dec reaching zero on this edge gives exactly T_ABIERTA cycles fully open.
            if ((boton_cerrar || hold_dec == '0) && !sensor && !boton_abrir)
              state_d = CERRANDO;
          end
          CERRANDO: begin
            if (boton_abrir || call || (sensor && !nudge_now)) begin
              state_d    = ABRIENDO;
              reab_d     = reab_inc;
              atendido_d = call;
            end else if (fin_cierre) begin
              state_d = CERRADA;
              reab_d  = '0;
            end else if (stroke_exp) begin
              falla_d = 1'b1;
            end else begin
              stroke_d = stroke_q + 1'b1;
            end
          end
        endcase
      end
    end

    if (state_d != state_q) stroke_d = '0;
`ifdef NUDGE_EN
    if (!falla_d && state_d == CERRANDO && reab_d == RW'(MAX_REAPERTURAS))
      aviso_d = aviso_d | sel;
`endif

    motor_abrir_d  = !falla_d && state_d == ABRIENDO;
    motor_cerrar_d = !falla_d && state_d == CERRANDO;
    trabajando_d   = falla_d || state_d != CERRADA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= CERRADA;
      hold_q         <= '0;
      stroke_q       <= '0;
      reab_q         <= '0;
      falla_q        <= 1'b0;
      motor_abrir_q  <= 1'b0;
      motor_cerrar_q <= 1'b0;
      atendido_q     <= 1'b0;
      trabajando_q   <= 1'b0;
      aviso_q        <= '0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      stroke_q       <= stroke_d;
      reab_q         <= reab_d;
      falla_q        <= falla_d;
      motor_abrir_q  <= motor_abrir_d;
      motor_cerrar_q <= motor_cerrar_d;
      atendido_q     <= atendido_d;
      trabajando_q   <= trabajando_d;
      aviso_q        <= aviso_d;
    end
  end

  assign motor_abrir    = motor_abrir_q;
  assign motor_cerrar   = motor_cerrar_q;
  assign estado_puertas = state_q;
  assign aviso          = aviso_q;
  assign atendido       = atendido_q;
  assign trabajando     = trabajando_q;
  assign falla          = falla_q;
endmodule

// File: tb/tb_control_puertas_param.sv
// Directed bench for control_puertas_param: cycle model compared every negedge plus literal checkpoints.
module tb_control_puertas_param;
  localparam int N  = 4;
  localparam int TA = 50;
  localparam int TM = 20;
  localparam int MR = 3;
  localparam int C_CERRADA = 0, C_ABIERTA = 1, C_CERRANDO = 2, C_ABRIENDO = 3;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] solicitud = '0;
  logic [1:0] piso_actual = '0;
  logic       moviendo = 0, boton_abrir = 0, boton_cerrar = 0, sensor = 0;
  logic       fin_apertura = 0, fin_cierre = 0;
  logic       motor_abrir, motor_cerrar, atendido, trabajando, falla;
  logic [1:0] estado_puertas;
  logic [3:0] aviso;

  always #5 clk = ~clk;

  control_puertas_param #(.N_PISOS(N), .T_ABIERTA(TA), .T_MOTOR_MAX(TM), .MAX_REAPERTURAS(MR)) dut (
    .clk(clk), .rst_n(rst_n), .solicitud(solicitud), .piso_actual(piso_actual),
    .moviendo(moviendo), .boton_abrir(boton_abrir), .boton_cerrar(boton_cerrar),
    .sensor(sensor), .fin_apertura(fin_apertura), .fin_cierre(fin_cierre),
    .motor_abrir(motor_abrir), .motor_cerrar(motor_cerrar), .estado_puertas(estado_puertas),
    .aviso(aviso), .atendido(atendido), .trabajando(trabajando), .falla(falla));

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: elapsed-cycle counters instead of a down-counting timer.
  int         m_est = C_CERRADA, m_open = 0, m_stroke = 0, m_reopen = 0;
  bit         m_falla = 0, m_atend = 0;
  logic [3:0] m_aviso = '0;

  function automatic bit nudge(input int reopen);
`ifdef NUDGE_EN
    return reopen >= MR;
`else
    return (reopen < 0);
`endif
  endfunction

  task automatic model_step();
    bit here, call;
    m_aviso = '0;
    m_atend = 0;
    if (!rst_n) begin
      m_est = C_CERRADA; m_open = 0; m_stroke = 0; m_reopen = 0; m_falla = 0;
      return;
    end
    if (m_falla) return;
    here = (int'(piso_actual) < N);
    call = here && solicitud[piso_actual];
    if (moviendo && m_est != C_CERRADA) begin
      m_falla = 1;
      return;
    end
    case (m_est)
      C_CERRADA:
        if (!moviendo && (call || boton_abrir)) begin
          m_est = C_ABRIENDO; m_stroke = 1; m_atend = call;
          if (here) m_aviso[piso_actual] = 1'b1;
        end
      C_ABRIENDO:
        if (fin_apertura) begin m_est = C_ABIERTA; m_open = 1; end
        else if (m_stroke >= TM) m_falla = 1;
        else m_stroke++;
      C_ABIERTA: begin
        m_atend = call;
        if ((boton_cerrar || m_open >= TA) && !sensor && !boton_abrir) begin
          m_est = C_CERRANDO; m_stroke = 1;
        end else if (sensor || boton_abrir || call) m_open = 1;
        else m_open++;
      end
      default: begin
        if (boton_abrir || call || (sensor && !nudge(m_reopen))) begin
          m_est = C_ABRIENDO; m_stroke = 1; m_atend = call;
          m_reopen = (m_reopen + 1 > MR) ? MR : m_reopen + 1;
        end else if (fin_cierre) begin m_est = C_CERRADA; m_reopen = 0; end
        else if (m_stroke >= TM) m_falla = 1;
        else m_stroke++;
      end
    endcase
    if (!m_falla && m_est == C_CERRANDO && nudge(m_reopen) && here)
      m_aviso[piso_actual] = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    chk("estado", 32'(estado_puertas), 32'(m_est));
    chk("motor_abrir", 32'(motor_abrir), 32'(!m_falla && m_est == C_ABRIENDO));
    chk("motor_cerrar", 32'(motor_cerrar), 32'(!m_falla && m_est == C_CERRANDO));
    chk("aviso", 32'(aviso), 32'(m_aviso));
    chk("atendido", 32'(atendido), 32'(m_atend));
    chk("trabajando", 32'(trabajando), 32'(m_falla || m_est != C_CERRADA));
    chk("falla", 32'(falla), 32'(m_falla));
    chk("motor_excl", 32'(motor_abrir & motor_cerrar), 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic count_until(input logic [1:0] st, input int bound, output int k);
    k = 0;
    while (estado_puertas != st && k < bound) begin
      tick(1);
      k++;
    end
  endtask

  int k, n;

  initial begin
    tick(2);
    chk("rst_estado", 32'(estado_puertas), 32'd0);
    chk("rst_trab", 32'(trabajando), 32'd0);
    chk("rst_motor", 32'({motor_abrir, motor_cerrar}), 32'd0);
    rst_n = 1; tick(1);

    solicitud = 4'b0100; piso_actual = 2; tick(1);
    chk("open_estado", 32'(estado_puertas), 32'd3);
    chk("open_motor", 32'(motor_abrir), 32'd1);
    chk("open_aviso", 32'(aviso), 32'h4);
    chk("open_atendido", 32'(atendido), 32'd1);
    solicitud = '0; tick(1);
    chk("aviso_pulse", 32'(aviso), 32'd0);
    chk("atendido_pulse", 32'(atendido), 32'd0);

    tick(2); fin_apertura = 1; tick(1); fin_apertura = 0;
    chk("abierta", 32'(estado_puertas), 32'd1);
    count_until(2'b10, 200, k);
    chk("hold_cycles", 32'(k), 32'd50);
    fin_cierre = 1; tick(1); fin_cierre = 0;
    chk("cerrada", 32'(estado_puertas), 32'd0);
    chk("trab_idle", 32'(trabajando), 32'd0);

    moviendo = 1; solicitud = 4'b0001; piso_actual = 0; tick(2);
    chk("moving_blocks", 32'(estado_puertas), 32'd0);
    moviendo = 0; tick(1);
    chk("open_after_stop", 32'(estado_puertas), 32'd3);
    solicitud = '0;
    tick(2); fin_apertura = 1; tick(1); fin_apertura = 0;
    boton_cerrar = 1; tick(1); boton_cerrar = 0;
    chk("close_btn", 32'(estado_puertas), 32'd2);
    sensor = 1; tick(1); sensor = 0;
    chk("sensor_reopen", 32'(estado_puertas), 32'd3);

    tick(1); fin_apertura = 1; tick(1); fin_apertura = 0;
    tick(40); sensor = 1; tick(1); sensor = 0;
    count_until(2'b10, 200, k);
    chk("reload_cycles", 32'(k), 32'd50);
    fin_cierre = 1; tick(1); fin_cierre = 0;

    boton_abrir = 1; tick(1); boton_abrir = 0;
    tick(1); fin_apertura = 1; tick(1); fin_apertura = 0;
    boton_abrir = 1; boton_cerrar = 1; tick(5);
    chk("both_btn", 32'(estado_puertas), 32'd1);
    boton_abrir = 0; tick(1);
    chk("cerrar_alone", 32'(estado_puertas), 32'd2);
    boton_cerrar = 0; fin_cierre = 1; tick(1); fin_cierre = 0;

    piso_actual = 1; boton_abrir = 1; tick(1); boton_abrir = 0;
    for (int r = 0; r < 3; r++) begin
      fin_apertura = 1; tick(1); fin_apertura = 0;
      boton_cerrar = 1; tick(1); boton_cerrar = 0;
      sensor = 1; tick(1); sensor = 0;
    end
    chk("reopen3", 32'(estado_puertas), 32'd3);
    fin_apertura = 1; tick(1); fin_apertura = 0;
    boton_cerrar = 1; tick(1); boton_cerrar = 0;
    chk("close4", 32'(estado_puertas), 32'd2);
    sensor = 1; tick(4);
`ifdef NUDGE_EN
    chk("nudge_hold", 32'(estado_puertas), 32'd2);
    chk("nudge_aviso", 32'(aviso), 32'h2);
    fin_cierre = 1; tick(1); fin_cierre = 0; sensor = 0;
    chk("nudge_done", 32'(estado_puertas), 32'd0);
`else
    chk("no_nudge", 32'(estado_puertas), 32'd3);
    sensor = 0; fin_apertura = 1; tick(1); fin_apertura = 0;
    boton_cerrar = 1; tick(1); boton_cerrar = 0;
    fin_cierre = 1; tick(1); fin_cierre = 0;
    chk("no_nudge_done", 32'(estado_puertas), 32'd0);
`endif

    piso_actual = 0; boton_abrir = 1; tick(1); boton_abrir = 0;
    n = 0;
    for (int i = 0; i < 100 && !falla; i++) begin
      if (motor_abrir) n++;
      tick(1);
    end
    chk("watchdog_cycles", 32'(n), 32'd20);
    chk("wd_falla", 32'(falla), 32'd1);
    chk("wd_motors", 32'({motor_abrir, motor_cerrar}), 32'd0);
    fin_apertura = 1; tick(5); fin_apertura = 0;
    chk("wd_frozen", 32'(estado_puertas), 32'd3);
    chk("wd_trab", 32'(trabajando), 32'd1);
    rst_n = 0; tick(1);
    chk("wd_cleared", 32'(falla), 32'd0);
    rst_n = 1; tick(1);

    boton_abrir = 1; tick(1); boton_abrir = 0; tick(2);
    chk("stroke_motor", 32'(motor_abrir), 32'd1);
    rst_n = 0; #1;
    chk("async_rst_motor", 32'(motor_abrir), 32'd0);
    chk("async_rst_estado", 32'(estado_puertas), 32'd0);
    tick(1); rst_n = 1; tick(1);

    boton_abrir = 1; tick(1); boton_abrir = 0;
    fin_apertura = 1; tick(1); fin_apertura = 0;
    chk("mov_abierta", 32'(estado_puertas), 32'd1);
    moviendo = 1; tick(1); moviendo = 0;
    chk("mov_falla", 32'(falla), 32'd1);
    tick(3);
    chk("mov_frozen", 32'(estado_puertas), 32'd1);
    chk("mov_trab", 32'(trabajando), 32'd1);
    rst_n = 0; tick(2); rst_n = 1; tick(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
